// File: rtl/bpsk_frame_scheduler.sv
// Transmit sequencer: serialises preamble, sync and FIFO payload bytes MSB first at the
// symbol rate, popping the FIFO at each payload byte boundary and flagging underrun.
module bpsk_frame_scheduler #(
    parameter int unsigned UNIT_SIZE = 8,
    parameter int unsigned PREAMBLE_LEN = 2,
    parameter logic [UNIT_SIZE-1:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [UNIT_SIZE-1:0] SYNC_BYTE = 8'hD3,
    parameter int unsigned SYM_DIV = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     frame_len,
    input  logic                 fifo_valid,
    input  logic [UNIT_SIZE-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 bit_out,
    output logic                 bit_strobe,
    output logic                 tx_active,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    localparam int unsigned DIV_W = $clog2(SYM_DIV);
    localparam int unsigned BIT_W = (UNIT_SIZE > 1) ? $clog2(UNIT_SIZE) : 1;
    localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SYM_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UNIT_SIZE - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSync,
        StPayload,
        StFinish
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [LEN_W-1:0]     byte_q, byte_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [UNIT_SIZE-1:0] shift_q, shift_d;
    logic                 underrun_q, underrun_d;

    logic sending;
    logic bit_end;
    logic boundary;
    logic fetch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_q      <= '0;
            pre_q      <= '0;
            byte_q     <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            pre_q      <= pre_d;
            byte_q     <= byte_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            underrun_q <= underrun_d;
        end
    end

    assign sending  = (state_q == StPreamble) || (state_q == StSync) || (state_q == StPayload);
    assign bit_end  = (div_q == DIV_LAST);
    assign boundary = sending && bit_end && (bit_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        pre_d      = pre_q;
        byte_d     = byte_q;
        len_d      = len_q;
        shift_d    = shift_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;
        fetch      = 1'b0;

        if (sending) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
            if (bit_end) begin
                bit_d   = boundary ? '0 : bit_q + 1'b1;
                shift_d = shift_q << 1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start && (frame_len != '0)) begin
                    len_d   = frame_len;
                    shift_d = PREAMBLE_BYTE;
                    div_d   = '0;
                    bit_d   = '0;
                    pre_d   = PRE_W'(1);
                    byte_d  = '0;
                    state_d = StPreamble;
                end
            end
            StPreamble: begin
                if (boundary) begin
                    if (pre_q == PRE_LAST) begin
                        shift_d = SYNC_BYTE;
                        state_d = StSync;
                    end else begin
                        pre_d   = pre_q + 1'b1;
                        shift_d = PREAMBLE_BYTE;
                    end
                end
            end
            StSync: begin
                fetch = boundary;
            end
            StPayload: begin
                if (boundary) begin
                    if (byte_q == len_q) begin
                        state_d = StFinish;
                    end else begin
                        fetch = 1'b1;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A missing byte aborts the frame; the pulse is registered so it shows in IDLE.
        if (fetch) begin
            if (fifo_valid) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_data;
                byte_d   = byte_q + 1'b1;
                state_d  = StPayload;
            end else begin
                underrun_d = 1'b1;
                state_d    = StIdle;
            end
        end
    end

    always_comb begin
        tx_active  = sending;
        busy       = (state_q != StIdle);
        done       = (state_q == StFinish);
        bit_strobe = sending && (div_q == '0);
        bit_out    = sending && shift_q[UNIT_SIZE-1];
        underrun   = underrun_q;
    end

endmodule
